// File: rtl/ai_core_cmd_feeder.sv
// Command ingress stage for ai_core: buffers host words in a FIFO and dispatches them
// through a registered output, gated by credits mirroring ai_core's command buffer slots.
module ai_core_cmd_feeder #(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned FifoDepth  = 8,
  parameter int unsigned NumCredits = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [DataWidth-1:0]               in_data_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  output logic [DataWidth-1:0]               out_data_o,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  input  logic                               credit_return_i,
  input  logic                               flush_i,
  output logic [$clog2(FifoDepth+1)-1:0]     fill_o,
  output logic [$clog2(NumCredits+1)-1:0]    credits_o,
  output logic                               overflow_err_o,
  output logic                               busy_o
);

  localparam int unsigned PtrW  = $clog2(FifoDepth);
  localparam int unsigned FillW = $clog2(FifoDepth + 1);
  localparam int unsigned CredW = $clog2(NumCredits + 1);

  typedef logic [PtrW:0] ptr_t;

  ptr_t                 wr_ptr_q, wr_ptr_d;
  ptr_t                 rd_ptr_q, rd_ptr_d;
  logic [FillW-1:0]     fill_q, fill_d;
  logic [CredW-1:0]     credits_q, credits_d;
  logic                 overflow_q, overflow_d;
  logic [DataWidth-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic [DataWidth-1:0] mem_q [FifoDepth];

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  // No push-through at full: readiness ignores a same-cycle pop.
  assign in_ready_o = !rst_i && !flush_i && !fifo_full;
  assign push       = in_valid_i && in_ready_o;
  assign pop        = !fifo_empty && (credits_q != '0) && (!out_valid_q || out_ready_i) &&
                      !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
      case ({push, pop})
        2'b10:   fill_d = fill_q + FillW'(1);
        2'b01:   fill_d = fill_q - FillW'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  // Output register: a pop reloads it, a handshake without a pop empties it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[rd_ptr_q[PtrW-1:0]];
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // The credit is consumed when the word enters the output register, not at handshake.
  always_comb begin
    credits_d  = credits_q;
    overflow_d = overflow_q;
    if (pop && !credit_return_i) begin
      credits_d = credits_q - CredW'(1);
    end else if (credit_return_i && !pop) begin
      if (credits_q == CredW'(NumCredits)) begin
        overflow_d = 1'b1;
      end else begin
        credits_d = credits_q + CredW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      credits_q   <= CredW'(NumCredits);
      overflow_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      credits_q   <= credits_d;
      overflow_q  <= overflow_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= in_data_i;
    end
  end

  assign out_data_o     = out_data_q;
  assign out_valid_o    = out_valid_q;
  assign fill_o         = fill_q;
  assign credits_o      = credits_q;
  assign overflow_err_o = overflow_q;
  assign busy_o         = !rst_i && (!fifo_empty || out_valid_q);

endmodule
